// File: rtl/ble_pkg.sv
// ble_pkg: shared FSM state type, framing constants and baud helper for the BLE TX path
package ble_pkg;

    typedef enum logic [2:0] {IDLE, CHECK, LOAD, SEND, TERM, CSUM, GAP} ble_tx_state_t;

    localparam logic [7:0] BLE_TERM     = 8'h0A;
    localparam logic [7:0] BLE_CSUM_ESC = 8'h8A;

    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

    function automatic int rr_dist(input int i, input int rr, input int n);
        return (i >= rr) ? i - rr : i - rr + n;
    endfunction

endpackage

// File: rtl/ble_tx_arbiter_uart_tx.sv
// uart_tx: 8N1 serializer, LSB first, each bit held CPB clocks; tx_done pulses after the stop bit
module uart_tx #(
    parameter int CPB = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_tx_start,
    input  logic [7:0] i_tx_data,
    output logic       o_txd,
    output logic       o_tx_busy,
    output logic       o_tx_done
);
    localparam int CW = $clog2(CPB + 1);

    logic [8:0]    r_shift;
    logic [3:0]    r_bit;
    logic [CW-1:0] r_cnt;

    // start bit on request, then shift data and stop bit out, one bit per CPB clocks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_txd     <= 1'b1;
            o_tx_busy <= 1'b0;
            o_tx_done <= 1'b0;
            r_shift   <= '1;
            r_bit     <= '0;
            r_cnt     <= '0;
        end else begin
            o_tx_done <= 1'b0;
            if (!o_tx_busy) begin
                if (i_tx_start) begin
                    o_txd     <= 1'b0;
                    r_shift   <= {1'b1, i_tx_data};
                    o_tx_busy <= 1'b1;
                    r_bit     <= '0;
                    r_cnt     <= '0;
                end
            end else if (r_cnt != CW'(CPB - 1)) begin
                r_cnt <= r_cnt + CW'(1);
            end else begin
                r_cnt <= '0;
                if (r_bit == 4'd9) begin
                    o_tx_busy <= 1'b0;
                    o_tx_done <= 1'b1;
                end else begin
                    o_txd   <= r_shift[0];
                    r_shift <= {1'b1, r_shift[8:1]};
                    r_bit   <= r_bit + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/ble_tx_arbiter.sv
// ble_tx_arbiter: round-robin arbiter framing requester payloads onto the BLE UART TX line
// Macro BLE_TX_CHECKSUM_EN: append the XOR of the payload (0x0A escaped to 0x8A) before the terminator
module ble_tx_arbiter
    import ble_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BYTES = 12,
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD      = 115200,
    parameter int GAP_CLKS  = 1000
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_REQ-1:0]                     i_req_valid,
    input  logic [NUM_REQ-1:0][7:0]                i_req_len,
    input  logic [NUM_REQ-1:0][MAX_BYTES-1:0][7:0] i_req_data,
    output logic [NUM_REQ-1:0]                     o_req_ack,
    output logic [NUM_REQ-1:0]                     o_req_err,
    output logic                                   o_ble_txd,
    output logic                                   o_busy,
    output logic [$clog2(NUM_REQ)-1:0]             o_grant_id,
    output logic                                   o_frame_done
);
    localparam int IW  = $clog2(NUM_REQ);
    localparam int BW  = $clog2(MAX_BYTES);
    localparam int GW  = $clog2(GAP_CLKS + 1);
    localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
`ifdef BLE_TX_CHECKSUM_EN
    localparam ble_tx_state_t AFTER_PAYLOAD = CSUM;
`else
    localparam ble_tx_state_t AFTER_PAYLOAD = TERM;
`endif

    ble_tx_state_t            r_state, w_next;
    logic                     r_first;
    logic [GW-1:0]            r_cnt;
    logic [IW-1:0]            r_rr, r_win, r_grant, w_win;
    logic                     w_any;
    int                       w_best;
    logic [MAX_BYTES-1:0][7:0] r_buf;
    logic [7:0]               r_len, r_idx, w_len, w_tx_data;
    logic                     w_bad, w_start, w_tx_busy, w_tx_done;
    logic [NUM_REQ-1:0]       w_ack, w_err;
`ifdef BLE_TX_CHECKSUM_EN
    logic [7:0]               r_csum, w_csum;
`endif

    assign w_len        = i_req_len[r_win];
    assign w_bad        = (w_len == 8'd0) || (w_len > 8'(MAX_BYTES));
    assign o_req_ack    = w_ack;
    assign o_req_err    = w_err;
    assign o_busy       = !(r_state == IDLE || r_state == CHECK);
    assign o_grant_id   = r_grant;
    assign o_frame_done = (r_state == GAP) && r_first;
`ifdef BLE_TX_CHECKSUM_EN
    assign w_tx_data = (r_state == TERM) ? BLE_TERM :
                       (r_state == CSUM) ? ((r_csum == BLE_TERM) ? BLE_CSUM_ESC : r_csum) :
                       r_buf[r_idx[BW-1:0]];
`else
    assign w_tx_data = (r_state == TERM) ? BLE_TERM : r_buf[r_idx[BW-1:0]];
`endif

    // pick the valid requester closest to the round-robin pointer
    always_comb begin
        w_win  = '0;
        w_any  = 1'b0;
        w_best = NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i_req_valid[i] && rr_dist(i, int'(r_rr), NUM_REQ) < w_best) begin
                w_best = rr_dist(i, int'(r_rr), NUM_REQ);
                w_win  = IW'(i);
                w_any  = 1'b1;
            end
        end
    end

`ifdef BLE_TX_CHECKSUM_EN
    // XOR of the winner's payload, captured alongside the data on ack
    always_comb begin
        w_csum = '0;
        for (int k = 0; k < MAX_BYTES; k++) begin
            if (k < int'(w_len)) w_csum = w_csum ^ i_req_data[r_win][k];
        end
    end
`endif

    // next-state and handshake/start strobes
    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_ack   = '0;
        w_err   = '0;
        case (r_state)
            IDLE:  if (w_any) w_next = CHECK;
            CHECK: begin
                if (!i_req_valid[r_win]) begin
                    w_next = IDLE;
                end else if (w_bad) begin
                    w_err[r_win] = 1'b1;
                    w_next       = IDLE;
                end else begin
                    w_ack[r_win] = 1'b1;
                    w_next       = LOAD;
                end
            end
            LOAD: begin
                w_start = 1'b1;
                w_next  = SEND;
            end
            SEND:  if (w_tx_done) w_next = (r_idx + 8'd1 < r_len) ? LOAD : AFTER_PAYLOAD;
`ifdef BLE_TX_CHECKSUM_EN
            CSUM: begin
                w_start = r_first;
                if (w_tx_done) w_next = TERM;
            end
`endif
            TERM: begin
                w_start = r_first;
                if (w_tx_done) w_next = GAP;
            end
            GAP:   if (r_cnt == GW'(GAP_CLKS - 1)) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // state register with entry flag and per-state cycle counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_first <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_first <= (w_next != r_state);
            r_cnt   <= (w_next != r_state) ? '0 : r_cnt + GW'(1);
        end
    end

    // winner latch, rr pointer, payload capture and byte index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr    <= '0;
            r_win   <= '0;
            r_grant <= '0;
            r_buf   <= '0;
            r_len   <= '0;
            r_idx   <= '0;
`ifdef BLE_TX_CHECKSUM_EN
            r_csum  <= '0;
`endif
        end else begin
            if (r_state == IDLE) r_win <= w_win;
            if (|w_ack || |w_err) r_rr <= (r_win == IW'(NUM_REQ - 1)) ? '0 : r_win + IW'(1);
            if (|w_ack) begin
                r_buf   <= i_req_data[r_win];
                r_len   <= w_len;
                r_grant <= r_win;
                r_idx   <= '0;
`ifdef BLE_TX_CHECKSUM_EN
                r_csum  <= w_csum;
`endif
            end
            if (r_state == SEND && w_next == LOAD) r_idx <= r_idx + 8'd1;
        end
    end

    uart_tx #(.CPB(CPB)) u_tx (
        .clk        (clk),
        .rst        (rst),
        .i_tx_start (w_start && !w_tx_busy),
        .i_tx_data  (w_tx_data),
        .o_txd      (o_ble_txd),
        .o_tx_busy  (w_tx_busy),
        .o_tx_done  (w_tx_done)
    );

endmodule

// File: tb/tb_ble_tx_arbiter.sv
// tb_ble_tx_arbiter: directed bench with a UART-decoding scoreboard for ble_tx_arbiter
module tb_ble_tx_arbiter;
    localparam int N   = 4;
    localparam int MB  = 12;
    localparam int CPB = 10;
    localparam int GAP = 40;
`ifdef BLE_TX_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic [N-1:0]               req_valid = '0;
    logic [N-1:0][7:0]          req_len = '0;
    logic [N-1:0][MB-1:0][7:0]  req_data = '0;
    logic [N-1:0]               req_ack, req_err;
    logic                       ble_txd, busy, frame_done;
    logic [1:0]                 grant_id;

    int checks = 0, failures = 0, cyc = 0, bytes_seen = 0, done_cnt = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    ble_tx_arbiter #(
        .NUM_REQ(N), .MAX_BYTES(MB), .CLK_FREQ(1_000_000), .BAUD(100_000), .GAP_CLKS(GAP)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(req_valid), .i_req_len(req_len), .i_req_data(req_data),
        .o_req_ack(req_ack), .o_req_err(req_err), .o_ble_txd(ble_txd),
        .o_busy(busy), .o_grant_id(grant_id), .o_frame_done(frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // UART decoder on the falling edge: every cycle of a bit must match its first cycle
    bit         d_act = 1'b0, d_ok;
    int         d_cnt;
    logic       d_val;
    logic [7:0] d_byte;
    logic [8:0] d_exp;
    always @(negedge clk) begin
        cyc++;
        if (frame_done === 1'b1) done_cnt++;
        if (rst) d_act = 1'b0;
        else if (!d_act) begin
            if (ble_txd === 1'b0) begin
                d_act = 1'b1; d_cnt = 0; d_val = 1'b0; d_ok = 1'b1; d_byte = '0;
            end
        end else begin
            d_cnt++;
            if (d_cnt == 10 * CPB) begin
                d_act = 1'b0;
                bytes_seen++;
                checks++;
                assert (d_ok && d_val === 1'b1) else begin
                    failures++;
                    $error("FAIL bit_timing observed ok=%0d stop=%0b expected ok=1 stop=1", d_ok, d_val);
                end
                if (exp_q.size() != 0) d_exp = {1'b0, exp_q.pop_front()};
                else d_exp = 9'h100;
                checks++;
                assert ({1'b0, d_byte} === d_exp) else begin
                    failures++;
                    $error("FAIL line_byte observed=0x%0h expected=0x%0h", d_byte, d_exp);
                end
            end else if (d_cnt % CPB == 0) begin
                d_val = ble_txd;
                if (d_cnt <= 8 * CPB) d_byte = {ble_txd, d_byte[7:1]};
            end else if (ble_txd !== d_val) d_ok = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic send_exp(input logic [MB-1:0][7:0] d, input int len);
        logic [7:0] x;
        x = '0;
        for (int k = 0; k < len; k++) begin
            exp_q.push_back(d[k]);
            x ^= d[k];
        end
        if (CS == 1) exp_q.push_back(x == 8'h0A ? 8'h8A : x);
        exp_q.push_back(8'h0A);
    endtask

    task automatic set_req(input int i, input int len, input logic [MB-1:0][7:0] d);
        req_len[i]   = 8'(len);
        req_data[i]  = d;
        req_valid[i] = 1'b1;
    endtask

    task automatic wait_ack(output logic [N-1:0] a, output logic [N-1:0] e, input int lim);
        a = '0;
        e = '0;
        for (int k = 0; k < lim; k++) begin
            tick(1);
            if (req_ack != 0 || req_err != 0) begin
                a = req_ack;
                e = req_err;
                return;
            end
        end
    endtask

    task automatic wait_frame(input string tag, input int lim);
        int  start;
        bit  ok;
        start = done_cnt;
        ok    = 1'b0;
        for (int k = 0; k < lim && !ok; k++) begin
            tick(1);
            if (done_cnt > start && !busy) ok = 1'b1;
        end
        chk(tag, 32'(ok), 1);
    endtask

    logic [N-1:0]      a, e;
    logic [MB-1:0][7:0] d;
    logic [N-1:0]      ord [3] = '{4'b0001, 4'b0010, 4'b1000};
    int                t0, bs, base;

    initial begin
        tick(3);
        chk("rst_txd", 32'(ble_txd), 1);
        chk("rst_ack", 32'(req_ack), 0);
        chk("rst_err", 32'(req_err), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant", 32'(grant_id), 0);
        chk("rst_done", 32'(frame_done), 0);
        rst = 1'b0;
        tick(2);

        d = '0; d[0] = 8'h12; d[1] = 8'h34;
        set_req(0, 2, d);
        send_exp(d, 2);
        t0 = cyc;
        wait_ack(a, e, 10);
        chk("single_ack", 32'(a), 32'h1);
        chk("single_ack_latency", 32'(cyc - t0), 1);
        tick(1);
        req_valid[0] = 1'b0;
        chk("single_busy", 32'(busy), 1);
        chk("single_txd_load", 32'(ble_txd), 1);
        tick(1);
        chk("single_start_bit", 32'(ble_txd), 0);
        wait_frame("single_frame_done", 2000);
        chk("single_grant", 32'(grant_id), 0);
        chk("single_queue_empty", 32'(exp_q.size()), 0);

        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);

        d = '0; d[0] = 8'hA0; set_req(0, 1, d); send_exp(d, 1);
        d = '0; d[0] = 8'hB1; d[1] = 8'hB2; set_req(1, 2, d); send_exp(d, 2);
        d = '0; d[0] = 8'hD3; set_req(3, 1, d); send_exp(d, 1);
        base = done_cnt;
        for (int j = 0; j < 3; j++) begin
            wait_ack(a, e, 3000);
            chk("rr_order", 32'(a), 32'(ord[j]));
            chk("rr_after_gap", 32'(done_cnt - base), 32'(j));
            chk("rr_idle_at_ack", 32'(busy), 0);
            tick(1);
            req_valid = req_valid & ~a;
        end
        wait_frame("rr_last_frame", 3000);
        chk("rr_grant", 32'(grant_id), 3);
        chk("rr_queue_empty", 32'(exp_q.size()), 0);

        bs = bytes_seen;
        d = '0;
        set_req(2, 0, d);
        wait_ack(a, e, 10);
        chk("rej_len0_err", 32'(e), 32'h4);
        chk("rej_len0_ack", 32'(a), 0);
        tick(1);
        req_len[2] = 8'd13;
        wait_ack(a, e, 10);
        chk("rej_len13_err", 32'(e), 32'h4);
        chk("rej_busy", 32'(busy), 0);
        tick(1);
        req_valid[2] = 1'b0;
        tick(5);
        chk("rej_txd_high", 32'(ble_txd), 1);
        chk("rej_no_bytes", 32'(bytes_seen - bs), 0);
        d = '0; d[0] = 8'h31; set_req(3, 1, d); send_exp(d, 1);
        d = '0; d[0] = 8'h11; set_req(1, 1, d); send_exp(d, 1);
        wait_ack(a, e, 10);
        chk("rej_rr_advanced", 32'(a), 32'h8);
        tick(1);
        req_valid[3] = 1'b0;
        wait_ack(a, e, 3000);
        chk("rej_next_req1", 32'(a), 32'h2);
        tick(1);
        req_valid[1] = 1'b0;
        wait_frame("rej_frames_done", 3000);
        chk("rej_queue_empty", 32'(exp_q.size()), 0);

        bs = bytes_seen;
        d = '0;
        for (int k = 0; k < MB; k++) d[k] = 8'(k);
        set_req(0, MB, d);
        send_exp(d, MB);
        wait_ack(a, e, 10);
        chk("max_len_ack", 32'(a), 32'h1);
        tick(1);
        req_valid[0] = 1'b0;
        wait_frame("max_len_frame", 5000);
        chk("max_len_bytes", 32'(bytes_seen - bs), 32'(MB + 1 + CS));
        chk("max_len_queue_empty", 32'(exp_q.size()), 0);

`ifdef BLE_TX_CHECKSUM_EN
        d = '0; d[0] = 8'h0F; d[1] = 8'h05;
        set_req(0, 2, d);
        exp_q.push_back(8'h0F); exp_q.push_back(8'h05); exp_q.push_back(8'h8A); exp_q.push_back(8'h0A);
        wait_ack(a, e, 3000);
        chk("csum_ack", 32'(a), 32'h1);
        tick(1);
        req_valid[0] = 1'b0;
        wait_frame("csum_frame", 3000);
        chk("csum_queue_empty", 32'(exp_q.size()), 0);
`endif

        bs = bytes_seen;
        d = '0; d[0] = 8'h55; d[1] = 8'h00; d[2] = 8'h33;
        set_req(1, 3, d);
        exp_q.push_back(8'h55);
        wait_ack(a, e, 3000);
        chk("midrst_ack", 32'(a), 32'h2);
        tick(1);
        req_valid[1] = 1'b0;
        for (int k = 0; k < 500 && bytes_seen == bs; k++) tick(1);
        for (int k = 0; k < 20 && ble_txd !== 1'b0; k++) tick(1);
        tick(3);
        chk("midrst_line_low", 32'(ble_txd), 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_txd_high", 32'(ble_txd), 1);
        chk("midrst_busy", 32'(busy), 0);
        tick(2);
        rst = 1'b0;
        tick(2);
        chk("midrst_byte0_only", 32'(exp_q.size()), 0);
        d = '0; d[0] = 8'h5A;
        set_req(2, 1, d);
        send_exp(d, 1);
        wait_ack(a, e, 10);
        chk("midrst_new_ack", 32'(a), 32'h4);
        tick(1);
        req_valid[2] = 1'b0;
        wait_frame("midrst_new_frame", 3000);
        chk("midrst_new_grant", 32'(grant_id), 2);
        chk("midrst_queue_empty", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ble_tx_arbiter.md
Name: ble_tx_arbiter

Overview:
Shares the single BLE UART transmit line (FPGA to BLE module) between several telemetry requesters, for example MPU angles, PID state and motor duty.
- Round-robin arbitration between requesters.
- Captures the granted requester's payload and serializes it as 8N1 UART bytes.
- Appends the 0x0A terminator, so frames match the newline-delimited framing the receive path already uses.
- Drives the pin that is currently tied idle-high.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
MAX_BYTES, 12, maximum payload bytes per frame, terminator excluded
CLK_FREQ, 100_000_000, clk frequency in Hz
BAUD, 115200, UART bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (868 at defaults)
GAP_CLKS, 1000, idle-high clocks enforced between frames

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester frame request; held until acked
req_len  in  NUM_REQ x 8  payload length per requester
req_data  in  NUM_REQ x MAX_BYTES x 8  payload bytes; byte 0 is sent first
req_ack  out  NUM_REQ  one-hot 1-cycle pulse; payload captured this cycle
req_err  out  NUM_REQ  one-hot 1-cycle pulse; request rejected
ble_txd  out  1  serial out to BLE module RX; idle high
busy  out  1  high from capture through the end of GAP
grant_id  out  $clog2(NUM_REQ)  requester of the current/last frame
frame_done  out  1  1-cycle pulse after the terminator stop bit completes

Behaviour:
- Reset values: ble_txd=1, req_ack=0, req_err=0, busy=0, grant_id=0, frame_done=0, rr pointer=0. State returns to IDLE.
- Reset mid-frame: ble_txd goes high immediately (async); the partial frame is discarded.
- Handshake: the requester asserts req_valid with stable len/data and holds them until req_ack or req_err. After the pulse, it may change its data or deassert.
- Round-robin: search starts at rr pointer. The winner index is priority; rr pointer becomes winner+1 mod NUM_REQ on ack or err.
- FSM states:
  - IDLE: if any req_valid, select the winner. Go to CHECK.
  - CHECK (1 cycle):
    - If len==0 or len>MAX_BYTES: pulse req_err[winner], go to IDLE. Nothing transmitted.
    - Else: pulse req_ack[winner], copy data and len into the local buffer, set grant_id and busy. Go to LOAD.
  - LOAD: issue tx_start with buffer[idx], idx=0 initially. Go to SEND.
  - SEND: wait for tx_done.
    - If more payload bytes remain: idx++, go to LOAD.
    - Else: go to TERM.
  - TERM: send 0x0A, wait for tx_done, then go to GAP.
  - GAP: count GAP_CLKS cycles with ble_txd high. Pulse frame_done on GAP entry. busy drops on exit. Go to IDLE.
- Latency: req_valid seen in IDLE at cycle N gives ack at N+1. The start bit falls at N+3.
- Frame duration: (len+1) x 10 x CLKS_PER_BIT cycles, plus GAP_CLKS.
- Payload bytes equal to 0x0A are sent unmodified; requesters must not generate them.
- Requests arriving while busy wait; they are never dropped.
- A requester deasserting req_valid before ack simply withdraws its request.
- UART format: LSB first, 1 start bit, 8 data bits, 1 stop bit. Each bit is held exactly CLKS_PER_BIT cycles.

Optional Feature:
BLE_TX_CHECKSUM_EN
- Defined: after the last payload byte, send the XOR of all payload bytes, then 0x0A. If the checksum equals 0x0A, send 0x8A instead. Frame length becomes len+2 bytes.
- Undefined: no checksum byte is sent, and the CSUM state is absent.

Decomposition:
- Package ble_pkg:
  - ble_tx_state_t enum (IDLE, CHECK, LOAD, SEND, TERM, CSUM, GAP)
  - BLE_TERM = 8'h0A
  - BLE_CSUM_ESC = 8'h8A
  - function clks_per_bit(freq, baud)
- Sub-module uart_tx:
  - ports clk, rst, tx_start, tx_data[7:0], txd, tx_busy, tx_done (1-cycle pulse after the stop bit).
  - Instantiated once.

Test Plan:
- Single request: req 0, len 2, data {0x12,0x34} gives ack[0] 1 cycle later. Line decodes to 0x12,0x34,0x0A; frame_done pulses; grant_id=0.
- Contention: req_valid=4'b1011 all held, rr=0 gives frame order 0,1,3. Each ack occurs only after the previous frame's GAP ends.
- Rejection: req 2 with len=0, then len=13 gives req_err[2] pulses. ble_txd stays high throughout; rr pointer advances to 3.
- Boundary: len=MAX_BYTES=12, bytes 0x00..0x0B gives 13 bytes on the line. Every bit width measures 868 cycles.
- Reset mid-frame: assert rst during byte 1 gives ble_txd=1 within the same cycle and busy=0. A new request after release sends a full, clean frame.
- With BLE_TX_CHECKSUM_EN: data {0x0F,0x05} gives bytes 0x0F,0x05,0x8A,0x0A, because the checksum 0x0A is escaped to 0x8A.
